// File: rtl/piso.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | piso : parallel-in serial-out shift register (load > shift > hold)    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module piso #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             rst,
  input  logic             clk,
  input  logic             load,
  input  logic             shen,
  output logic [WIDTH-1:0] sreg,
  output logic             ser_out
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;
  logic             w_ser;

  // Shift direction and the serial tap are fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sreg[WIDTH-2:0], FILL};
      assign w_ser     = r_sreg[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {FILL, r_sreg[WIDTH-1:1]};
      assign w_ser     = r_sreg[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= data_in;
    end else if (shen) begin
      r_sreg <= w_shifted;
    end
  end

  assign sreg    = r_sreg;
  assign ser_out = w_ser;

endmodule
`default_nettype wire

// File: tb/tb_piso.sv
`default_nettype none
// tb_piso : directed self-checking bench for piso (MSB-first 8-bit and LSB-first 4-bit).
module tb_piso;

  logic       clk;
  logic       rst;
  logic [7:0] a_data;
  logic       a_load;
  logic       a_shen;
  logic [7:0] a_sreg;
  logic       a_ser;
  logic [3:0] b_data;
  logic       b_load;
  logic       b_shen;
  logic [3:0] b_sreg;
  logic       b_ser;

  int total;
  int bad;

  piso #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL(1'b0)) u_dut_a (
    .data_in (a_data),
    .rst     (rst),
    .clk     (clk),
    .load    (a_load),
    .shen    (a_shen),
    .sreg    (a_sreg),
    .ser_out (a_ser)
  );

  piso #(.WIDTH(4), .MSB_FIRST(1'b0), .FILL(1'b0)) u_dut_b (
    .data_in (b_data),
    .rst     (rst),
    .clk     (clk),
    .load    (b_load),
    .shen    (b_shen),
    .sreg    (b_sreg),
    .ser_out (b_ser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] es, input logic eo);
    check({tag, ".sreg"}, {56'd0, a_sreg}, {56'd0, es});
    check({tag, ".ser"},  {63'd0, a_ser},  {63'd0, eo});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] es, input logic eo);
    check({tag, ".sreg"}, {60'd0, b_sreg}, {60'd0, es});
    check({tag, ".ser"},  {63'd0, b_ser},  {63'd0, eo});
  endtask

  logic [7:0] exp_a [8];
  logic [3:0] exp_b [4];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; a_data = 8'h55; a_load = 1'b0; a_shen = 1'b0;
    b_data = 4'h0; b_load = 1'b0; b_shen = 1'b0;
    @(negedge clk);

    // Reset held 5 cycles, then released
    tick(5);
    chk_a("reset", 8'h00, 1'b0);
    chk_b("reset_b", 4'h0, 1'b0);
    rst = 1'b0;
    tick(1);
    chk_a("post_reset_hold", 8'h00, 1'b0);

    // Load, then hold 3 edges
    a_load = 1'b1;
    tick(1);
    chk_a("load55", 8'h55, 1'b0);
    a_load = 1'b0;
    tick(3);
    chk_a("hold55", 8'h55, 1'b0);

    // Shift out MSB first, FILL=0
    exp_a = '{8'hAA, 8'h54, 8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    a_shen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_a($sformatf("shift%0d", i), exp_a[i], exp_a[i][7]);
    end
    tick(2);
    chk_a("exhausted", 8'h00, 1'b0);

    // Priority: load beats shift, rst beats load
    a_data = 8'hC3; a_load = 1'b1; a_shen = 1'b1;
    tick(1);
    chk_a("load_over_shift", 8'hC3, 1'b1);
    a_load = 1'b0;
    tick(1);
    chk_a("shift_after_load", 8'h86, 1'b1);
    rst = 1'b1; a_load = 1'b1;
    tick(1);
    chk_a("rst_over_load", 8'h00, 1'b0);
    rst = 1'b0; a_load = 1'b0; a_shen = 1'b0;

    // Reset mid-shift, then reload
    a_data = 8'hFF; a_load = 1'b1;
    tick(1);
    a_load = 1'b0; a_shen = 1'b1;
    tick(3);
    chk_a("midshift", 8'hF8, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_a("rst_midshift", 8'h00, 1'b0);
    rst = 1'b0; a_shen = 1'b0;
    tick(1);
    chk_a("no_resume", 8'h00, 1'b0);
    a_data = 8'h81; a_load = 1'b1;
    tick(1);
    chk_a("reload81", 8'h81, 1'b1);

    // data_in changes while load=0 are ignored
    a_load = 1'b0; a_data = 8'h3C;
    tick(2);
    chk_a("data_ignored", 8'h81, 1'b1);

    // Reload mid-shift overwrites and keeps shifting
    a_shen = 1'b1;
    tick(2);
    chk_a("pre_reload", 8'h04, 1'b0);
    a_data = 8'hE0; a_load = 1'b1;
    tick(1);
    chk_a("reload_mid", 8'hE0, 1'b1);
    a_load = 1'b0;
    tick(1);
    chk_a("reload_shift", 8'hC0, 1'b1);
    a_shen = 1'b0;

    // LSB-first 4-bit variant
    b_data = 4'b1011; b_load = 1'b1;
    tick(1);
    chk_b("b_load", 4'b1011, 1'b1);
    b_load = 1'b0; b_shen = 1'b1;
    exp_b = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_b($sformatf("b_shift%0d", i), exp_b[i], exp_b[i][0]);
    end
    tick(1);
    chk_b("b_exhausted", 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in serial-out shift register.
- Captures a WIDTH-bit parallel word on a load strobe, then shifts it out one bit per clock while shift enable is high.
- Used as the serializer stage feeding single-wire serial links. Both the full register contents and the current serial bit are exposed.

Parameters:
- WIDTH, 8: register / parallel data width in bits (legal range 2..64).
- MSB_FIRST, 1: 1 = shift left and emit the MSB first; 0 = shift right and emit the LSB first.
- FILL, 1'b0: bit value shifted into the vacated end on each shift.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word, sampled only when load=1 at a clock edge.
- load  input  1  parallel load strobe.
- shen  input  1  shift enable.
- sreg  output  WIDTH  current shift-register contents (registered).
- ser_out  output  1  serial output bit.
- Port order for positional instantiation: data_in, rst, clk, load, shen, sreg, ser_out.

Behaviour:
- Reset (synchronous, active-high):
  - One clock domain (clk); no asynchronous behaviour.
  - rst=1 at a posedge clk sets sreg to all zeros, so ser_out is 0.
  - rst has priority over load and shen.
  - Before the first reset edge, sreg is undefined (X in simulation).
- Priority at each posedge clk: rst > load > shen > hold.
- Load: load=1 and rst=0 -> sreg <= data_in. This happens even when shen=1 in the same cycle; that cycle does not shift.
- Shift: shen=1, load=0, rst=0:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], FILL}.
  - MSB_FIRST=0: sreg <= {FILL, sreg[WIDTH-1:1]}.
- Hold: all control inputs low -> sreg unchanged.
- ser_out:
  - Combinational from the register: sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0].
  - The first serial bit is valid in the cycle immediately after the load edge (zero additional latency).
  - Each subsequent shift edge presents the next bit.
- Latency: a WIDTH-bit word needs 1 load edge plus WIDTH-1 shift edges to present all bits on ser_out.
- Exhaustion: shen held past WIDTH shifts keeps shifting FILL in.
  - With FILL=0, sreg reaches 0 after WIDTH shifts and ser_out stays 0.
  - No wrap-around or rotation.
- Reset mid-shift: contents are discarded; sreg=0 after the edge. The word is not resumed.
- Reload mid-shift: load=1 overwrites remaining bits immediately; shifting continues from the new word if shen stays high.
- data_in changes while load=0 have no effect.
- No internal counter, done flag or handshake. Word framing is the upstream controller's responsibility.

Test Plan:
- Reset: rst=1 for 5 cycles with data_in=8'h55, load=0, shen=0 -> sreg=8'h00, ser_out=0; release rst -> sreg holds 8'h00.
- Load: data_in=8'b01010101, load=1 for one edge -> sreg=8'h55, ser_out=0. Then load=0, shen=0 for 3 edges -> sreg stays 8'h55.
- Shift-out (MSB_FIRST=1, FILL=0): after loading 8'h55, hold shen=1.
  - ser_out sequence per edge: 1,0,1,0,1,0,1,0.
  - sreg sequence: AA,54,A8,50,A0,40,80,00; then remains 00 with ser_out=0.
- Priority: load=1 and shen=1 on the same edge with data_in=8'hC3 -> sreg=8'hC3 (no shift). Next edge with shen only -> 8'h86. rst=1 together with load=1 -> sreg=8'h00.
- Reset mid-operation: load 8'hFF, shift 3 edges (sreg=8'hF8), assert rst one edge -> sreg=8'h00. Reload 8'h81 -> ser_out=1.
- LSB_first variant (MSB_FIRST=0, WIDTH=4): load 4'b1011, shen=1 -> ser_out 1,1,0,1; sreg 0101,0010,0001,0000.
